// File: rtl/bp_trace_encoder_pkg.sv
// Shared types and constants for the branch/discontinuity trace encoder.
package bp_trace_encoder_pkg;

  // Default PC width. This is also the width of the packet's pc field.
  localparam int unsigned pc_width_lp = 32;

  // Byte distance between consecutive sequential commits.
  localparam int unsigned instr_stride_lp = 4;

  // Packet presented by the commit stage. instr rides along but the encoder ignores it.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } bp_commit_pkt_s;

endpackage : bp_trace_encoder_pkg

// File: rtl/bp_trace_encoder_seq_detect.sv
// Combinational check of whether a commit breaks sequential control flow.
// Raises emit when there is no prior commit, or when pc != last_pc + stride.
// The sum wraps modulo 2^pc_width_p.
module bp_trace_encoder_seq_detect
  import bp_trace_encoder_pkg::*;
#(
  parameter int unsigned pc_width_p     = pc_width_lp,
  parameter int unsigned instr_stride_p = instr_stride_lp
) (
  input  logic [pc_width_p-1:0] pc,
  input  logic [pc_width_p-1:0] last_pc,
  input  logic                  have_prev,
  output logic                  emit
);

  // Truncate the stride to the PC width so the addition wraps naturally.
  localparam logic [pc_width_p-1:0] stride_lp = pc_width_p'(instr_stride_p);

  logic [pc_width_p-1:0] expected_pc;

  // Next sequential PC and the discontinuity decision.
  always_comb begin
    expected_pc = last_pc + stride_lp;
    emit        = !have_prev || (pc != expected_pc);
  end

endmodule : bp_trace_encoder_seq_detect

// File: rtl/bp_trace_encoder.sv
// Commit-stage trace encoder. It emits the committed PC as a trace word only
// on control-flow discontinuities and compresses sequential commits away.
// Outputs are registered, so the trace word appears one cycle after the commit.
module bp_trace_encoder
  import bp_trace_encoder_pkg::*;
#(
  parameter int unsigned pc_width_p     = pc_width_lp,
  parameter int unsigned instr_stride_p = instr_stride_lp
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  bp_commit_pkt_s        commit_pkt_i,
  input  logic                  commit_valid_i,
  output logic [pc_width_p-1:0] trace_data_o,
  output logic                  trace_valid_o
);

  logic [pc_width_p-1:0] last_pc_reg;
  logic                  have_prev_reg;
  logic [pc_width_p-1:0] trace_data_reg;
  logic                  trace_valid_reg;

  logic [pc_width_p-1:0] commit_pc;
  logic                  emit;

  // The packet carries a 32-bit pc. Only the low pc_width_p bits take part.
  assign commit_pc = commit_pkt_i.pc[pc_width_p-1:0];

  bp_trace_encoder_seq_detect #(
    .pc_width_p     (pc_width_p),
    .instr_stride_p (instr_stride_p)
  ) u_seq_detect (
    .pc        (commit_pc),
    .last_pc   (last_pc_reg),
    .have_prev (have_prev_reg),
    .emit      (emit)
  );

  // Track the last committed PC and register the trace strobe and data.
  // Reset takes priority, so a commit during reset is dropped.
  // Idle cycles hold the history, which lets sequentiality span gaps.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_pc_reg     <= '0;
      have_prev_reg   <= 1'b0;
      trace_data_reg  <= '0;
      trace_valid_reg <= 1'b0;
    end else if (commit_valid_i) begin
      last_pc_reg     <= commit_pc;
      have_prev_reg   <= 1'b1;
      trace_valid_reg <= emit;
      if (emit) begin
        trace_data_reg <= commit_pc;
      end
    end else begin
      trace_valid_reg <= 1'b0;
    end
  end

  assign trace_data_o  = trace_data_reg;
  assign trace_valid_o = trace_valid_reg;

endmodule : bp_trace_encoder

// File: tb/tb_bp_trace_encoder.sv
// Directed testbench for bp_trace_encoder. Each cycle drives one commit or idle
// slot and checks the registered outputs against hand-computed values.
module tb_bp_trace_encoder;
  import bp_trace_encoder_pkg::*;

  logic           clk_i;
  logic           reset_i;
  bp_commit_pkt_s commit_pkt_i;
  logic           commit_valid_i;
  logic [31:0]    trace_data_o;
  logic           trace_valid_o;

  int tests_run;
  int tests_failed;

  bp_trace_encoder #(
    .pc_width_p     (32),
    .instr_stride_p (4)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .commit_pkt_i   (commit_pkt_i),
    .commit_valid_i (commit_valid_i),
    .trace_data_o   (trace_data_o),
    .trace_valid_o  (trace_valid_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Count one comparison and report it if it differs.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then settle just after the rising edge.
  task automatic tick(input logic rst, input logic vld, input logic [31:0] pc);
    @(negedge clk_i);
    reset_i            = rst;
    commit_valid_i     = vld;
    commit_pkt_i.pc    = pc;
    commit_pkt_i.instr = $urandom;
    @(posedge clk_i);
    #1;
  endtask

  // Check both outputs and print one line for this transaction.
  task automatic expect_out(input string tag, input logic vld, input logic [31:0] data);
    $display("[TB] %s: valid=%0b data=0x%08h (exp valid=%0b data=0x%08h)",
             tag, trace_valid_o, trace_data_o, vld, data);
    check_val({tag, ".valid"}, {31'd0, trace_valid_o}, {31'd0, vld});
    check_val({tag, ".data"}, trace_data_o, data);
  endtask

  initial begin
    tests_run          = 0;
    tests_failed       = 0;
    reset_i            = 1'b1;
    commit_valid_i     = 1'b0;
    commit_pkt_i       = '0;

    // Reset state.
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    expect_out("reset", 1'b0, 32'h0);

    // Test 1: two sequential runs give two emits.
    tick(1'b0, 1'b1, 32'h0000_1000); expect_out("t1_1000", 1'b1, 32'h0000_1000);
    tick(1'b0, 1'b1, 32'h0000_1004); expect_out("t1_1004", 1'b0, 32'h0000_1000);
    tick(1'b0, 1'b1, 32'h0000_2000); expect_out("t1_2000", 1'b1, 32'h0000_2000);
    tick(1'b0, 1'b1, 32'h0000_2004); expect_out("t1_2004", 1'b0, 32'h0000_2000);
    tick(1'b0, 1'b0, 32'h0000_3000); expect_out("t1_idle", 1'b0, 32'h0000_2000);

    // Test 2: invalid cycles with a toggling pc do nothing after reset.
    tick(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, (i % 2 == 0) ? 32'hDEAD_BEEC : 32'h0000_0004);
      expect_out($sformatf("t2_idle%0d", i), 1'b0, 32'h0);
    end

    // Test 3: an idle gap keeps sequentiality, and a repeated PC is a discontinuity.
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h0000_1000); expect_out("t3_1000", 1'b1, 32'h0000_1000);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 32'h0000_5000);
      expect_out($sformatf("t3_gap%0d", i), 1'b0, 32'h0000_1000);
    end
    tick(1'b0, 1'b1, 32'h0000_1004); expect_out("t3_1004a", 1'b0, 32'h0000_1000);
    tick(1'b0, 1'b1, 32'h0000_1004); expect_out("t3_1004b", 1'b1, 32'h0000_1004);

    // Test 4: the address wrap counts as sequential.
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'hFFFF_FFFC); expect_out("t4_fffc", 1'b1, 32'hFFFF_FFFC);
    tick(1'b0, 1'b1, 32'h0000_0000); expect_out("t4_wrap", 1'b0, 32'hFFFF_FFFC);

    // Test 5: a backward step and a +8 step give back-to-back emits.
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h0000_3000); expect_out("t5_3000", 1'b1, 32'h0000_3000);
    tick(1'b0, 1'b1, 32'h0000_2FFC); expect_out("t5_2ffc", 1'b1, 32'h0000_2FFC);
    tick(1'b0, 1'b1, 32'h0000_3004); expect_out("t5_3004", 1'b1, 32'h0000_3004);
    tick(1'b0, 1'b1, 32'h0000_300C); expect_out("t5_300c", 1'b1, 32'h0000_300C);

    // Test 6: reset wins over a simultaneous commit.
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h0000_1000); expect_out("t6_1000", 1'b1, 32'h0000_1000);
    tick(1'b1, 1'b1, 32'h0000_1004); expect_out("t6_rst",  1'b0, 32'h0000_0000);
    tick(1'b0, 1'b1, 32'h0000_1008); expect_out("t6_1008", 1'b1, 32'h0000_1008);

    // The first commit after reset is emitted even when it is 0x4, the successor of the reset last_pc.
    tick(1'b0, 1'b1, 32'h0000_0000); expect_out("t7_zero",  1'b1, 32'h0000_0000);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h0000_0004); expect_out("t7_first4", 1'b1, 32'h0000_0004);
    tick(1'b0, 1'b1, 32'h0000_0008); expect_out("t7_seq8",   1'b0, 32'h0000_0004);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_bp_trace_encoder
